sbox_lut_loader: RTL

Register-bus initiator that programs the 32-entry, 5-bit ASCON S-box lookup table held in the S-box register file. It walks the table row by row and issues one 32-bit write per row over the register interface, where `sbox_registers_lut` is the responder. It sits beside the ASCON core and runs once after reset, or again whenever software or the top-level requests a reload. An optional read-back pass checks that the table landed intact.

---
 rtl/sbox_lut_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sbox_lut_loader.sv
// sbox_lut_loader: register-bus initiator that programs the 32-entry, 5-bit
// ASCON S-box LUT, one 32-bit write per 4-entry row (8 rows).
// Optional read-back pass is compiled in when SBOX_LOADER_VERIFY_EN is defined.
package sbox_lut_loader_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } reg_req_t;

   typedef struct packed {
      logic        ready;
      logic [31:0] rdata;
      logic        error;
   } reg_rsp_t;
endpackage

module sbox_lut_loader
   import sbox_lut_loader_pkg::*;
#(
   parameter logic [31:0]      BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned      ROW_STRIDE = 4,
   parameter logic [31:0][4:0] SBOX_TABLE = {
      5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
      5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
      5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
      5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04}
) (
   input  logic     clk_i,
   input  logic     rst_n_i,
   input  logic     start_i,
   output logic     busy_o,
   output logic     done_o,
   output logic     error_o,
   output reg_req_t sbox_reg_req_o,
   input  reg_rsp_t sbox_reg_rsp_i
);

   localparam logic [31:0] STRIDE     = 32'(ROW_STRIDE);
   localparam logic [31:0] ENTRY_MASK = 32'h1f1f_1f1f;

   // S_VERIFY gets its own code so the default build keeps a 3-state FSM
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
`ifdef SBOX_LOADER_VERIFY_EN
      , S_VERIFY = 2'd3
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  row_q, row_d, row_nx;
   logic        err_q, err_d;
   reg_req_t    req_q, req_d;
   logic [31:0] row_word [8];

   // Each row packs four 5-bit entries into the low bits of consecutive bytes
   for (genvar r = 0; r < 8; r++) begin : g_row
      assign row_word[r] = {3'b000, SBOX_TABLE[4*r+3], 3'b000, SBOX_TABLE[4*r+2],
                            3'b000, SBOX_TABLE[4*r+1], 3'b000, SBOX_TABLE[4*r]};
   end

   function automatic reg_req_t mk_req(input logic wr, input logic [2:0] r,
                                       input logic [31:0] word);
      reg_req_t q;
      q.valid = 1'b1;
      q.addr  = BASE_ADDR + 32'(r) * STRIDE;
      q.write = wr;
      q.wdata = wr ? word : 32'h0;
      q.wstrb = wr ? 4'hF : 4'h0;
      return q;
   endfunction

   // Next state, row counter and the next registered request
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      err_d   = err_q;
      req_d   = req_q;
      row_nx  = row_q + 3'd1;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               row_d   = 3'd0;
               err_d   = 1'b0;
               req_d   = mk_req(1'b1, 3'd0, row_word[0]);
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (sbox_reg_rsp_i.ready) begin
               if (sbox_reg_rsp_i.error) begin
                  err_d   = 1'b1;
                  req_d   = '0;
                  state_d = S_DONE;
               end else if (row_q == 3'd7) begin
                  // ending on the explicit row-7 compare means the 3-bit
                  // counter wrap never triggers a second pass
`ifdef SBOX_LOADER_VERIFY_EN
                  row_d   = 3'd0;
                  req_d   = mk_req(1'b0, 3'd0, 32'h0);
                  state_d = S_VERIFY;
`else
                  req_d   = '0;
                  state_d = S_DONE;
`endif
               end else begin
                  row_d = row_nx;
                  req_d = mk_req(1'b1, row_nx, row_word[row_nx]);
               end
            end
         end
`ifdef SBOX_LOADER_VERIFY_EN
         S_VERIFY: begin
            if (sbox_reg_rsp_i.ready) begin
               if (sbox_reg_rsp_i.error ||
                   ((sbox_reg_rsp_i.rdata & ENTRY_MASK) != row_word[row_q])) begin
                  err_d   = 1'b1;
                  req_d   = '0;
                  state_d = S_DONE;
               end else if (row_q == 3'd7) begin
                  req_d   = '0;
                  state_d = S_DONE;
               end else begin
                  row_d = row_nx;
                  req_d = mk_req(1'b0, row_nx, 32'h0);
               end
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

`ifndef SBOX_LOADER_VERIFY_EN
   // read data only matters for the read-back pass
   logic unused_rdata;
   assign unused_rdata = ^sbox_reg_rsp_i.rdata;
`endif

   // State, counter, sticky error and request registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         row_q   <= 3'd0;
         err_q   <= 1'b0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         err_q   <= err_d;
         req_q   <= req_d;
      end
   end

`ifdef SBOX_LOADER_VERIFY_EN
   assign busy_o = (state_q == S_WRITE) || (state_q == S_VERIFY);
`else
   assign busy_o = (state_q == S_WRITE);
`endif
   assign done_o         = (state_q == S_DONE);
   assign error_o        = err_q;
   assign sbox_reg_req_o = req_q;

endmodule
